matrix_core_sequencer: RTL and testbench

MATRIX_CORE_SEQUENCER -- requirements
Module: matrix_core_sequencer

---
 rtl/matrix_core_sequencer_pkg.sv | 22 ++
 rtl/matrix_core_sequencer_rsp_fifo.sv | 54 +++++
 rtl/matrix_core_sequencer.sv | 154 +++++++++++++++
 tb/tb_matrix_core_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_core_sequencer_pkg.sv
// rtl/matrix_core_sequencer_pkg.sv - shared op encodings, FSM states and default widths
package matrix_core_sequencer_pkg;

   localparam int MATRIX_CORE_DATA_WIDTH = 8;
   localparam int MATRIX_CORE_ADDR_WIDTH = 8;
   localparam int MATRIX_CORE_RSP_DEPTH  = 2;

   typedef enum logic [1:0] {
      MATRIX_CORE_LOAD_W  = 2'd0,
      MATRIX_CORE_LOAD_X  = 2'd1,
      MATRIX_CORE_COMPUTE = 2'd2,
      MATRIX_CORE_RSVD    = 2'd3
   } matrix_core_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/matrix_core_sequencer_rsp_fifo.sv
// rtl/matrix_core_sequencer_rsp_fifo.sv - seq_rsp_fifo, power-of-two response FIFO
// Push while full is accepted only when a pop happens in the same cycle.
module seq_rsp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (PW+1)'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/matrix_core_sequencer.sv
// rtl/matrix_core_sequencer.sv - SRAM read sequencer feeding words to the matrix core
// Optional MATRIX_SEQ_LEN_CHECK_EN rejects zero-length and address-wrapping commands.
module matrix_core_sequencer
   import matrix_core_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = MATRIX_CORE_DATA_WIDTH,
   parameter int ADDR_WIDTH = MATRIX_CORE_ADDR_WIDTH,
   parameter int RSP_DEPTH  = MATRIX_CORE_RSP_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_vld,
   output logic                  cmd_rdy,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH-1:0] cmd_len,
   output logic                  mem_req_vld,
   input  logic                  mem_req_rdy,
   output logic [1:0]            mem_req_cfg,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_vld,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   output logic                  core_vld,
   input  logic                  core_rdy,
   output logic [DATA_WIDTH-1:0] core_data,
   output logic [1:0]            core_op,
   output logic                  core_last,
   output logic                  done,
   output logic                  err
);
   localparam int CW = $clog2(RSP_DEPTH) + 1;
   localparam int LW = ADDR_WIDTH + 1;

   seq_state_e            state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LW-1:0]         len_q, len_d, req_cnt_q, req_cnt_d, pop_cnt_q, pop_cnt_d;
   logic [CW-1:0]         outst_q, outst_d;
   logic                  cmd_rdy_q, cmd_rdy_d, done_q, done_d, err_q, err_d;

   logic                  cmd_fire, cmd_bad, req_fire, rsp_ok, push, pop;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic [CW:0]           credit_used;

`ifdef MATRIX_SEQ_LEN_CHECK_EN
   logic [LW-1:0] span;
   assign span    = {1'b0, cmd_base} + {1'b0, cmd_len};
   assign cmd_bad = (cmd_op == MATRIX_CORE_RSVD) || (cmd_len == '0) ||
                    (span > {1'b1, {ADDR_WIDTH{1'b0}}});
`else
   assign cmd_bad = (cmd_op == MATRIX_CORE_RSVD);
`endif

   // Credit counts words either in flight or parked in the FIFO, so a stalled core throttles issue.
   assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
   assign mem_req_vld = (state_q == ISSUE) && (credit_used < (CW+1)'(RSP_DEPTH));
   assign cmd_fire    = cmd_vld && cmd_rdy_q;
   assign req_fire    = mem_req_vld && mem_req_rdy;
   assign rsp_ok      = mem_rsp_vld && (outst_q != '0);
   assign core_vld    = !fifo_empty;
   assign pop         = core_vld && core_rdy;
   assign push        = rsp_ok && (!fifo_full || pop);

   seq_rsp_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (mem_rsp_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      len_d     = len_q;
      req_cnt_d = req_cnt_q;
      pop_cnt_d = pop_cnt_q;
      err_d     = 1'b0;
      outst_d   = outst_q + CW'(req_fire) - CW'(rsp_ok);
      if (pop) pop_cnt_d = pop_cnt_q + LW'(1);
      if (req_fire) begin
         addr_d    = addr_q + ADDR_WIDTH'(1);
         req_cnt_d = req_cnt_q + LW'(1);
      end
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               if (cmd_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d   = ISSUE;
                  op_d      = cmd_op;
                  addr_d    = cmd_base;
                  // A zero length means the full address space.
                  len_d     = {cmd_len == '0, cmd_len};
                  req_cnt_d = '0;
                  pop_cnt_d = '0;
               end
            end
         end
         ISSUE: if (req_fire && (req_cnt_q == len_q - LW'(1))) state_d = DRAIN;
         DRAIN: if ((outst_q == '0) && fifo_empty && (pop_cnt_q == len_q)) state_d = DONE;
         default: state_d = IDLE;
      endcase
      cmd_rdy_d = (state_d == IDLE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         req_cnt_q <= '0;
         pop_cnt_q <= '0;
         outst_q   <= '0;
         cmd_rdy_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         req_cnt_q <= req_cnt_d;
         pop_cnt_q <= pop_cnt_d;
         outst_q   <= outst_d;
         cmd_rdy_q <= cmd_rdy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign cmd_rdy      = cmd_rdy_q;
   assign mem_req_cfg  = op_q;
   assign mem_req_addr = addr_q;
   assign core_data    = core_vld ? fifo_data : '0;
   assign core_op      = op_q;
   assign core_last    = core_vld && (pop_cnt_q == len_q - LW'(1));
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_matrix_core_sequencer.sv
// tb/tb_matrix_core_sequencer.sv - directed bench with a 1-cycle SRAM model and core sink
module tb_matrix_core_sequencer;
   import matrix_core_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_vld, cmd_rdy;
   logic [1:0] cmd_op;
   logic [7:0] cmd_base, cmd_len;
   logic       mem_req_vld, mem_req_rdy;
   logic [1:0] mem_req_cfg;
   logic [7:0] mem_req_addr;
   logic       mem_rsp_vld;
   logic [7:0] mem_rsp_data;
   logic       core_vld, core_rdy, core_last, done, err;
   logic [7:0] core_data;
   logic [1:0] core_op;

   int total = 0;
   int bad   = 0;

   logic [7:0] req_addr_q[$];
   logic [1:0] req_cfg_q[$];
   logic [7:0] word_q[$];
   logic [1:0] wop_q[$];
   logic       last_q[$];
   int done_cnt = 0, err_cnt = 0, vld_seen = 0, stab_bad = 0;
   bit rdy_rand = 0, core_rand = 0, core_stall = 0, spur = 0;

   always #5 clk = ~clk;

   matrix_core_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_cfg(mem_req_cfg),
      .mem_req_addr(mem_req_addr), .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data),
      .core_vld(core_vld), .core_rdy(core_rdy), .core_data(core_data), .core_op(core_op),
      .core_last(core_last), .done(done), .err(err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SRAM model and core sink: everything moves at negedge, data = addr ^ 0x5A, 1-cycle latency.
   initial begin
      bit         pend = 0, hold_prev = 0;
      logic [7:0] pend_data = '0, hold_addr = '0;
      logic [1:0] hold_cfg = '0;
      mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_data = '0; core_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 0; hold_prev = 0; mem_rsp_vld = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (mem_req_vld) vld_seen++;
            if (hold_prev && (!mem_req_vld || mem_req_addr !== hold_addr || mem_req_cfg !== hold_cfg))
               stab_bad++;
            mem_rsp_vld  = pend || spur;
            mem_rsp_data = pend ? pend_data : 8'hEE;
            mem_req_rdy  = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            core_rdy     = core_stall ? 1'b0 : (core_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            pend = mem_req_vld && mem_req_rdy;
            if (pend) begin
               req_addr_q.push_back(mem_req_addr);
               req_cfg_q.push_back(mem_req_cfg);
               pend_data = mem_req_addr ^ 8'h5A;
            end
            hold_prev = mem_req_vld && !mem_req_rdy;
            hold_addr = mem_req_addr;
            hold_cfg  = mem_req_cfg;
            if (core_vld && core_rdy) begin
               word_q.push_back(core_data);
               wop_q.push_back(core_op);
               last_q.push_back(core_last);
            end
         end
      end
   end

   task automatic clear_logs();
      req_addr_q.delete(); req_cfg_q.delete(); word_q.delete(); wop_q.delete(); last_q.delete();
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] base, input logic [7:0] len);
      int t = 0;
      cmd_op = op; cmd_base = base; cmd_len = len; cmd_vld = 1'b1;
      while (!cmd_rdy && t < 100) begin @(negedge clk); t++; end
      check_eq("cmd_accept_tmo", t < 100, 1);
      @(negedge clk);
      cmd_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, input int d0);
      int t = 0;
      while (done_cnt == d0 && t < budget) begin @(negedge clk); t++; end
      check_eq({tag, "_done_tmo"}, t < budget, 1);
      repeat (3) @(negedge clk);
      check_eq({tag, "_done_once"}, done_cnt - d0, 1);
      check_eq({tag, "_rdy_back"}, cmd_rdy, 1);
   endtask

   task automatic check_run(input string tag, input logic [1:0] op, input logic [7:0] base, input int n);
      int ba = 0, bd = 0, bo = 0, bl = 0;
      logic [7:0] a;
      check_eq({tag, "_nreq"}, req_addr_q.size(), n);
      check_eq({tag, "_nword"}, word_q.size(), n);
      for (int i = 0; i < req_addr_q.size(); i++) begin
         a = base + 8'(i);
         if (req_addr_q[i] !== a || req_cfg_q[i] !== op) ba++;
      end
      for (int i = 0; i < word_q.size(); i++) begin
         a = base + 8'(i);
         if (word_q[i] !== (a ^ 8'h5A)) bd++;
         if (wop_q[i] !== op) bo++;
         if (last_q[i] !== (i == n - 1)) bl++;
      end
      check_eq({tag, "_addr_errs"}, ba, 0);
      check_eq({tag, "_data_errs"}, bd, 0);
      check_eq({tag, "_op_errs"}, bo, 0);
      check_eq({tag, "_last_errs"}, bl, 0);
   endtask

   initial begin
      int d0, e0, v0, t;
      rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_base = '0; cmd_len = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", {cmd_rdy, mem_req_vld, core_vld, core_last, done, err}, 0);
      check_eq("rst_addr", mem_req_addr, 0);
      check_eq("rst_data", core_data, 0);
      rst_n = 1'b1;
      #1 check_eq("rdy_before_edge", cmd_rdy, 0);
      @(negedge clk);
      check_eq("rdy_first_edge", cmd_rdy, 1);

      // LOAD_W base 0 len 16
      clear_logs(); d0 = done_cnt;
      send_cmd(MATRIX_CORE_LOAD_W, 8'h00, 8'd16);
      check_eq("t1_lat_vld", mem_req_vld, 1);
      check_eq("t1_lat_addr", mem_req_addr, 8'h00);
      check_eq("t1_busy", cmd_rdy, 0);
      wait_done("t1", 200, d0);
      check_run("t1", MATRIX_CORE_LOAD_W, 8'h00, 16);

      // LOAD_X crossing the top of the address space
      clear_logs(); d0 = done_cnt; e0 = err_cnt;
      send_cmd(MATRIX_CORE_LOAD_X, 8'hFE, 8'd4);
`ifdef MATRIX_SEQ_LEN_CHECK_EN
      check_eq("t2_err", err, 1);
      repeat (5) @(negedge clk);
      check_eq("t2_nreq", req_addr_q.size(), 0);
      check_eq("t2_errcnt", err_cnt - e0, 1);
`else
      wait_done("t2", 200, d0);
      check_run("t2", MATRIX_CORE_LOAD_X, 8'hFE, 4);
      check_eq("t2_noerr", err_cnt - e0, 0);
`endif

      // ending exactly at the top is legal in both builds
      clear_logs(); d0 = done_cnt;
      send_cmd(MATRIX_CORE_LOAD_X, 8'hFC, 8'd4);
      wait_done("t2b", 200, d0);
      check_run("t2b", MATRIX_CORE_LOAD_X, 8'hFC, 4);

      // COMPUTE with the core stalled: credit limits issue to RSP_DEPTH
      clear_logs(); d0 = done_cnt; core_stall = 1;
      send_cmd(MATRIX_CORE_COMPUTE, 8'h40, 8'd8);
      repeat (20) @(negedge clk);
      check_eq("t3_stall_nreq", req_addr_q.size(), 2);
      check_eq("t3_stall_vld", mem_req_vld, 0);
      check_eq("t3_head_vld", core_vld, 1);
      check_eq("t3_head_data", core_data, 8'h40 ^ 8'h5A);
      core_stall = 0;
      wait_done("t3", 200, d0);
      check_run("t3", MATRIX_CORE_COMPUTE, 8'h40, 8);

      // random backpressure on both sides
      clear_logs(); d0 = done_cnt; stab_bad = 0; rdy_rand = 1; core_rand = 1;
      send_cmd(MATRIX_CORE_LOAD_W, 8'h80, 8'd10);
      wait_done("t4", 600, d0);
      rdy_rand = 0; core_rand = 0;
      check_run("t4", MATRIX_CORE_LOAD_W, 8'h80, 10);
      check_eq("t4_stable", stab_bad, 0);

      // reserved op
      clear_logs(); e0 = err_cnt; v0 = vld_seen;
      send_cmd(MATRIX_CORE_RSVD, 8'h10, 8'd4);
      check_eq("t5_err", err, 1);
      check_eq("t5_rdy", cmd_rdy, 1);
      @(negedge clk);
      check_eq("t5_err_pulse", err, 0);
      repeat (4) @(negedge clk);
      check_eq("t5_no_vld", vld_seen - v0, 0);
      check_eq("t5_errcnt", err_cnt - e0, 1);

      // stray responses while idle must be dropped
      spur = 1;
      repeat (3) @(negedge clk);
      spur = 0;
      @(negedge clk);
      check_eq("t6_no_push", core_vld, 0);
      clear_logs(); d0 = done_cnt;
      send_cmd(MATRIX_CORE_LOAD_X, 8'h05, 8'd3);
      wait_done("t6", 200, d0);
      check_run("t6", MATRIX_CORE_LOAD_X, 8'h05, 3);

      // zero length
      clear_logs(); d0 = done_cnt; e0 = err_cnt;
      send_cmd(MATRIX_CORE_LOAD_W, 8'hF0, 8'd0);
`ifdef MATRIX_SEQ_LEN_CHECK_EN
      check_eq("t7_err", err, 1);
      repeat (5) @(negedge clk);
      check_eq("t7_nreq", req_addr_q.size(), 0);
`else
      wait_done("t7", 2000, d0);
      check_run("t7", MATRIX_CORE_LOAD_W, 8'hF0, 256);
      check_eq("t7_noerr", err_cnt - e0, 0);
`endif

      // reset in the middle of a command
      clear_logs(); d0 = done_cnt;
      send_cmd(MATRIX_CORE_LOAD_W, 8'h20, 8'd8);
      t = 0;
      while (req_addr_q.size() < 3 && t < 50) begin @(negedge clk); t++; end
      check_eq("t8_reach_req3", t < 50, 1);
      rst_n = 1'b0;
      #1;
      check_eq("t8_rst_ctrl", {cmd_rdy, mem_req_vld, core_vld, core_last, done, err}, 0);
      check_eq("t8_rst_addr", mem_req_addr, 0);
      check_eq("t8_rst_data", core_data, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("t8_rdy", cmd_rdy, 1);
      repeat (3) @(negedge clk);
      check_eq("t8_no_done", done_cnt - d0, 0);
      clear_logs(); d0 = done_cnt;
      send_cmd(MATRIX_CORE_COMPUTE, 8'h30, 8'd5);
      wait_done("t8", 200, d0);
      check_run("t8", MATRIX_CORE_COMPUTE, 8'h30, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
